zcu216_adc_rst_sequencer: RTL
=============================

# zcu216_adc_rst_sequencer

Reset sequencer that sits directly downstream of the ZCU216 clock infrastructure. It runs on the MMCM-generated `adc_clk`, synchronises the MMCM `mmcm_locked` flag into that domain, and holds `adc_rst` until lock has been stable for a programmable time. It then releases the ADC-domain logic in two stages, reset first and `ready` second, and counts lock-loss events for software.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronised-locked cycles required before reset release; legal range ≥2.
- `HOLD_CYCLES`, default 16: cycles between `adc_rst` deassertion and `ready` assertion; legal range ≥1.
- `CNT_W`, default 16: width of `lock_loss_cnt`.
- `adc_clk`  in  1  sole clock; MMCM CLKOUT0 after BUFG.
- `rst`  in  1  asynchronous, active-high reset.
- `mmcm_locked`  in  1  MMCM LOCKED; asynchronous to `adc_clk`.
- `sw_rst`  in  1  synchronous software reset request, `adc_clk` domain, level-sensitive.
- `clr_cnt`  in  1  synchronous single-cycle clear of `lock_loss_cnt`.
- `adc_rst`  out  1  active-high reset for ADC-domain logic; registered.
- `ready`  out  1  ADC-domain logic released and settled; registered.
- `state`  out  2  current FSM state: 0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN.
- `lock_loss_cnt`  out  CNT_W  saturating count of lock losses that occurred in RELEASE or RUN.

## Operation
- Reset (`rst`=1, asynchronous):
  - Both synchroniser flops are 0.
  - State is WAIT_LOCK, `adc_rst`=1, `ready`=0.
  - `stable_cnt`=0, `hold_cnt`=0, `lock_loss_cnt`=0.
- Synchroniser: a 2-flop chain carries `mmcm_locked` to `locked_s`. Nothing else samples `mmcm_locked`.
- `drop` = `!locked_s || sw_rst`.
- WAIT_LOCK: if `!drop`, go to STABLE with `stable_cnt`=0.
- STABLE:
  - If `drop`, go to WAIT_LOCK.
  - Else if `stable_cnt`==`LOCK_STABLE_CYCLES`-1, go to RELEASE with `hold_cnt`=0.
  - Else `stable_cnt`++.
- RELEASE:
  - If `drop`, go to WAIT_LOCK.
  - Else if `hold_cnt`==`HOLD_CYCLES`-1, go to RUN.
  - Else `hold_cnt`++.
- RUN: if `drop`, go to WAIT_LOCK.
- Outputs are registered and driven from the next state, so they change on the same edge as the state:
  - `adc_rst`=1 in WAIT_LOCK and STABLE, 0 otherwise.
  - `ready`=1 only in RUN.
- Lock-loss counting:
  - `lock_loss_cnt` increments on the edge that leaves RELEASE or RUN because `!locked_s`.
  - A loss in STABLE is not counted.
  - An exit caused by `sw_rst` alone is not counted. If `sw_rst` and `!locked_s` coincide, the loss is counted.
  - The count saturates at 2^CNT_W-1.
- `clr_cnt` behaviour:
  - `clr_cnt` alone sets the count to 0.
  - `clr_cnt` with a simultaneous increment sets the count to 1, so no event is lost.
- Counter widths: `stable_cnt` is $clog2(`LOCK_STABLE_CYCLES`) bits and `hold_cnt` is $clog2(`HOLD_CYCLES`)+1 bits. Neither wraps; both clear on entry to their state.
- A `rst` assertion mid-sequence returns every register to its reset value immediately. Deassertion of `rst` restarts from WAIT_LOCK.

## Timing
- Lock acquisition, with E0 = first edge sampling `mmcm_locked`=1:
  - `locked_s`=1 after E1.
  - STABLE at E2.
  - `adc_rst` falls at E(2+`LOCK_STABLE_CYCLES`).
  - `ready` rises at E(2+`LOCK_STABLE_CYCLES`+`HOLD_CYCLES`).
- Lock loss, with E0 = first edge sampling `mmcm_locked`=0:
  - `adc_rst`=1, `ready`=0 and the counter update all occur at E2.
  - Worst case is 3 `adc_clk` edges from the input transition.
- `sw_rst` sampled 1 at edge E: WAIT_LOCK, `adc_rst`=1 and `ready`=0 at E.
  - While `sw_rst` is held, the FSM stays in WAIT_LOCK.
  - After release, the full stable count restarts.
- A lock glitch shorter than one `adc_clk` period may be missed. This is acceptable because the MMCM does not produce such glitches.
- Timing constraint: `mmcm_locked` to the first synchroniser flop is a false path. Both synchroniser flops carry ASYNC_REG.

## Test plan
- Reset and acquisition (LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4): release `rst`, raise `mmcm_locked` before edge E0 -> `state` reads 1 at E2; `adc_rst` 1→0 at E10; `ready` 0→1 at E14; `lock_loss_cnt`=0.
- Early loss in STABLE: drop `mmcm_locked` for 3 cycles at E5, then restore -> WAIT_LOCK, `adc_rst` stays 1 throughout, count stays 0, full 8-cycle stable count restarts.
- Loss in RUN: from RUN, drop `mmcm_locked` -> `adc_rst`=1 and `ready`=0 exactly 3 edges later; `lock_loss_cnt`=1; relock -> release after the full 8+4 sequence again.
- `sw_rst` vs `clr_cnt`:
  - Pulse `sw_rst` 1 cycle in RUN -> WAIT_LOCK on that edge, count unchanged.
  - Assert `clr_cnt` on the same edge as a RUN lock-loss -> `lock_loss_cnt`=1.
- Saturation (CNT_W=2): force 5 lock losses from RUN -> count reads 1, 2, 3, 3, 3.
- Asynchronous reset mid-RELEASE: assert `rst` between edges -> `adc_rst`=1, `ready`=0, `state`=0 and `lock_loss_cnt`=0 with no clock edge required.

Source files
------------

// File: rtl/zcu216_adc_rst_sequencer.sv
// Reset sequencer for the ZCU216 ADC clock domain: synchronises MMCM lock, holds
// adc_rst until lock is stable, releases reset then ready, and counts lock losses.
module zcu216_adc_rst_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES        = 16,
    parameter int CNT_W              = 16
) (
    input  logic             adc_clk,
    input  logic             rst,
    input  logic             mmcm_locked,
    input  logic             sw_rst,
    input  logic             clr_cnt,
    output logic             adc_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int SC_W = $clog2(LOCK_STABLE_CYCLES);
    localparam int HC_W = $clog2(HOLD_CYCLES) + 1;

    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    // mmcm_locked -> sync_q1 is a false path; both flops stay together in placement.
    (* ASYNC_REG = "TRUE" *) logic sync_q1;
    (* ASYNC_REG = "TRUE" *) logic locked_s;

    state_t           state_q, state_nxt;
    logic [SC_W-1:0]  stable_cnt, stable_cnt_nxt;
    logic [HC_W-1:0]  hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0] loss_cnt, loss_cnt_nxt;
    logic             adc_rst_q, adc_rst_nxt;
    logic             ready_q, ready_nxt;
    logic             drop;
    logic             loss_evt;

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q1  <= mmcm_locked;
            locked_s <= sync_q1;
        end
    end

    assign drop = !locked_s || sw_rst;

    // Only a real lock loss out of a released state is counted; sw_rst alone is not.
    assign loss_evt = !locked_s && ((state_q == RELEASE) || (state_q == RUN));

    always_comb begin
        state_nxt      = state_q;
        stable_cnt_nxt = stable_cnt;
        hold_cnt_nxt   = hold_cnt;

        case (state_q)
            WAIT_LOCK: begin
                if (!drop) begin
                    state_nxt      = STABLE;
                    stable_cnt_nxt = '0;
                end
            end
            STABLE: begin
                if (drop) begin
                    state_nxt = WAIT_LOCK;
                end else if (stable_cnt == SC_LAST) begin
                    state_nxt    = RELEASE;
                    hold_cnt_nxt = '0;
                end else begin
                    stable_cnt_nxt = stable_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (drop) begin
                    state_nxt = WAIT_LOCK;
                end else if (hold_cnt == HC_LAST) begin
                    state_nxt = RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                if (drop) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase

        // Outputs are decoded from the next state so they move on the same edge.
        adc_rst_nxt = (state_nxt == WAIT_LOCK) || (state_nxt == STABLE);
        ready_nxt   = (state_nxt == RUN);
    end

    always_comb begin
        loss_cnt_nxt = loss_cnt;
        if (clr_cnt) begin
            loss_cnt_nxt = loss_evt ? CNT_W'(1) : '0;
        end else if (loss_evt && (loss_cnt != CNT_MAX)) begin
            loss_cnt_nxt = loss_cnt + 1'b1;
        end
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            loss_cnt   <= '0;
            adc_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            stable_cnt <= stable_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            loss_cnt   <= loss_cnt_nxt;
            adc_rst_q  <= adc_rst_nxt;
            ready_q    <= ready_nxt;
        end
    end

    assign adc_rst       = adc_rst_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign lock_loss_cnt = loss_cnt;

endmodule
